// File: rtl/memory_pkg.sv
// Shared memory-subsystem types for the L1 D-cache and its MSHR controller.
package memory_pkg;

    localparam int LINE_ADDR_W      = 26;
    localparam int L1C_MSHR_ENTRIES = 4;

    typedef logic [LINE_ADDR_W-1:0]                  line_addr_t;
    typedef logic [$clog2(L1C_MSHR_ENTRIES+1)-1:0]   mshr_pending_req_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } mshr_ctrl_state_e;

endpackage

// File: rtl/dcache_mshr_ctrl.sv
// L1 D-cache MSHR sequencer: merges/allocates misses, issues L2C line requests,
// retires answers and runs the drain-then-clear flush sequence.
module dcache_mshr_ctrl
    import memory_pkg::*;
#(
    parameter int MAX_OUTSTANDING = L1C_MSHR_ENTRIES
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              miss_valid_i,
    input  line_addr_t        miss_line_addr_i,
    output logic              miss_ready_o,

    input  logic              flush_i,
    output logic              flush_done_o,
    output logic              err_o,

    output line_addr_t        mshr_line_addr_o,
    output logic              mshr_clr_all_o,
    output logic              mshr_add_line_addr_o,
    output logic              mshr_put_wait_o,
    output logic              mshr_clr_hit_line_o,
    input  logic              mshr_hit_i,
    input  logic              mshr_req_available_i,
    input  logic              mshr_full_i,
    input  mshr_pending_req_t mshr_pending_req_i,
    input  line_addr_t        mshr_l2c_line_addr_i,

    output logic              l2c_req_valid_o,
    input  logic              l2c_req_ready_i,
    output line_addr_t        l2c_req_line_addr_o,

    input  logic              l2c_ans_valid_i,
    input  line_addr_t        l2c_ans_line_addr_i,
    output logic              l2c_ans_ready_o
);

    localparam mshr_pending_req_t MAX_PEND = mshr_pending_req_t'(MAX_OUTSTANDING);

    mshr_ctrl_state_e r_state;
    mshr_ctrl_state_e w_state_nxt;
    logic             r_req_valid;
    line_addr_t       r_req_line_addr;
    logic             r_err;

    logic w_ans_hs;
    logic w_miss_eval;
    logic w_add;
    logic w_clr_hit;
    logic w_issue;

    // The single compare port serves the answer when one is present, the miss otherwise.
    assign mshr_line_addr_o = l2c_ans_valid_i ? l2c_ans_line_addr_i : miss_line_addr_i;

    assign l2c_ans_ready_o = (r_state != CLEAR);
    assign w_ans_hs        = l2c_ans_valid_i && l2c_ans_ready_o;
    assign w_clr_hit       = w_ans_hs && mshr_hit_i;

    // Misses only see the compare port when no answer is using it.
    assign w_miss_eval  = (r_state == RUN) && !flush_i && !l2c_ans_valid_i;
    assign miss_ready_o = w_miss_eval && (mshr_hit_i || !mshr_full_i);
    assign w_add        = w_miss_eval && miss_valid_i && !mshr_hit_i && !mshr_full_i;

    assign w_issue = (r_state == RUN) && !flush_i && mshr_req_available_i
                   && (mshr_pending_req_i < MAX_PEND)
                   && (!r_req_valid || l2c_req_ready_i)
                   && !w_add && !w_clr_hit;

    assign mshr_clr_all_o       = (r_state == CLEAR);
    assign mshr_add_line_addr_o = w_add;
    assign mshr_put_wait_o      = w_issue;
    assign mshr_clr_hit_line_o  = w_clr_hit;

    assign flush_done_o        = (r_state == CLEAR);
    assign err_o               = r_err;
    assign l2c_req_valid_o     = r_req_valid;
    assign l2c_req_line_addr_o = r_req_line_addr;

    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            RUN:   if (flush_i) w_state_nxt = DRAIN;
            DRAIN: if ((mshr_pending_req_i == '0) && !r_req_valid && !l2c_ans_valid_i)
                       w_state_nxt = CLEAR;
            CLEAR: w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: non-blocking assignments for all sequential state to avoid ordering races.
            r_state         <= RUN;
            r_req_valid     <= 1'b0;
            r_req_line_addr <= '0;
            r_err           <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_req_valid     <= 1'b1;
                r_req_line_addr <= mshr_l2c_line_addr_i;
            end else if (l2c_req_ready_i) begin
                r_req_valid <= 1'b0;
            end
            if (w_ans_hs && !mshr_hit_i) r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_mshr_ctrl.sv
// Directed bench for dcache_mshr_ctrl: the bench plays the MSHR and L2C sides by hand.
module tb_dcache_mshr_ctrl;
    import memory_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              miss_valid_i;
    line_addr_t        miss_line_addr_i;
    logic              miss_ready_o;
    logic              flush_i;
    logic              flush_done_o;
    logic              err_o;
    line_addr_t        mshr_line_addr_o;
    logic              mshr_clr_all_o;
    logic              mshr_add_line_addr_o;
    logic              mshr_put_wait_o;
    logic              mshr_clr_hit_line_o;
    logic              mshr_hit_i;
    logic              mshr_req_available_i;
    logic              mshr_full_i;
    mshr_pending_req_t mshr_pending_req_i;
    line_addr_t        mshr_l2c_line_addr_i;
    logic              l2c_req_valid_o;
    logic              l2c_req_ready_i;
    line_addr_t        l2c_req_line_addr_o;
    logic              l2c_ans_valid_i;
    line_addr_t        l2c_ans_line_addr_i;
    logic              l2c_ans_ready_o;

    int n_total = 0;
    int n_pass  = 0;

    dcache_mshr_ctrl #(.MAX_OUTSTANDING(2)) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .miss_valid_i         (miss_valid_i),
        .miss_line_addr_i     (miss_line_addr_i),
        .miss_ready_o         (miss_ready_o),
        .flush_i              (flush_i),
        .flush_done_o         (flush_done_o),
        .err_o                (err_o),
        .mshr_line_addr_o     (mshr_line_addr_o),
        .mshr_clr_all_o       (mshr_clr_all_o),
        .mshr_add_line_addr_o (mshr_add_line_addr_o),
        .mshr_put_wait_o      (mshr_put_wait_o),
        .mshr_clr_hit_line_o  (mshr_clr_hit_line_o),
        .mshr_hit_i           (mshr_hit_i),
        .mshr_req_available_i (mshr_req_available_i),
        .mshr_full_i          (mshr_full_i),
        .mshr_pending_req_i   (mshr_pending_req_i),
        .mshr_l2c_line_addr_i (mshr_l2c_line_addr_i),
        .l2c_req_valid_o      (l2c_req_valid_o),
        .l2c_req_ready_i      (l2c_req_ready_i),
        .l2c_req_line_addr_o  (l2c_req_line_addr_o),
        .l2c_ans_valid_i      (l2c_ans_valid_i),
        .l2c_ans_line_addr_i  (l2c_ans_line_addr_i),
        .l2c_ans_ready_o      (l2c_ans_ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    endtask

    task automatic check_addr(input string tag, input line_addr_t obs, input line_addr_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Drive just after the active edge; check combinational outputs on the falling edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    // At most one MSHR control strobe in any cycle.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1)
            check("strobe_onehot",
                  $countones({mshr_clr_all_o, mshr_add_line_addr_o,
                              mshr_put_wait_o, mshr_clr_hit_line_o}) <= 1, 1'b1);
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0;
        miss_valid_i = 0; miss_line_addr_i = '0; flush_i = 0;
        mshr_hit_i = 0; mshr_req_available_i = 0; mshr_full_i = 0;
        mshr_pending_req_i = '0; mshr_l2c_line_addr_i = '0;
        l2c_req_ready_i = 0; l2c_ans_valid_i = 0; l2c_ans_line_addr_i = '0;

        #12;
        check("rst_req_valid", l2c_req_valid_o, 1'b0);
        check_addr("rst_req_addr", l2c_req_line_addr_o, '0);
        check("rst_err", err_o, 1'b0);
        check("rst_flush_done", flush_done_o, 1'b0);
        check("rst_clr_all", mshr_clr_all_o, 1'b0);
        check("rst_add", mshr_add_line_addr_o, 1'b0);
        check("rst_put_wait", mshr_put_wait_o, 1'b0);
        check("rst_clr_hit", mshr_clr_hit_line_o, 1'b0);
        tick();
        rst_ni = 1'b1;

        // Allocate 0x40 into an empty MSHR.
        tick();
        miss_valid_i = 1; miss_line_addr_i = 26'h40;
        mid();
        check("alloc_ready", miss_ready_o, 1'b1);
        check("alloc_add", mshr_add_line_addr_o, 1'b1);
        check("alloc_no_put", mshr_put_wait_o, 1'b0);
        check_addr("alloc_cmp_addr", mshr_line_addr_o, 26'h40);

        // Issue it.
        tick();
        miss_valid_i = 0; mshr_req_available_i = 1; mshr_l2c_line_addr_i = 26'h40;
        mid();
        check("issue_put", mshr_put_wait_o, 1'b1);
        check("issue_no_add", mshr_add_line_addr_o, 1'b0);
        tick();
        mshr_req_available_i = 0; mshr_pending_req_i = 1; mshr_l2c_line_addr_i = 26'h55;
        check("req_valid", l2c_req_valid_o, 1'b1);
        check_addr("req_addr", l2c_req_line_addr_o, 26'h40);

        // L2C not ready for three cycles: request holds.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", l2c_req_valid_o, 1'b1);
            check_addr("hold_addr", l2c_req_line_addr_o, 26'h40);
        end
        l2c_req_ready_i = 1;
        tick();
        l2c_req_ready_i = 0;
        check("req_drop_on_ready", l2c_req_valid_o, 1'b0);

        // Merge a second miss to 0x40.
        miss_valid_i = 1; miss_line_addr_i = 26'h40; mshr_hit_i = 1;
        mid();
        check("merge_ready", miss_ready_o, 1'b1);
        check("merge_no_add", mshr_add_line_addr_o, 1'b0);

        // Answer 0x40 retires it.
        tick();
        miss_valid_i = 0; l2c_ans_valid_i = 1; l2c_ans_line_addr_i = 26'h40;
        miss_line_addr_i = 26'h99;
        mid();
        check("ans_ready", l2c_ans_ready_o, 1'b1);
        check("ans_clr_hit", mshr_clr_hit_line_o, 1'b1);
        check_addr("ans_cmp_addr", mshr_line_addr_o, 26'h40);
        check("ans_miss_blocked", miss_ready_o, 1'b0);

        // Full MSHR stalls a new miss until an answer frees an entry.
        tick();
        l2c_ans_valid_i = 0; mshr_pending_req_i = 0;
        miss_valid_i = 1; miss_line_addr_i = 26'h80; mshr_hit_i = 0; mshr_full_i = 1;
        mid();
        check("full_stall", miss_ready_o, 1'b0);
        check("full_no_add", mshr_add_line_addr_o, 1'b0);
        tick();
        l2c_ans_valid_i = 1; l2c_ans_line_addr_i = 26'hC0; mshr_hit_i = 1;
        mid();
        check("full_ans_stall", miss_ready_o, 1'b0);
        check("full_ans_clr_hit", mshr_clr_hit_line_o, 1'b1);
        check_addr("full_ans_cmp", mshr_line_addr_o, 26'hC0);
        tick();
        l2c_ans_valid_i = 0; mshr_hit_i = 0; mshr_full_i = 0;
        mid();
        check("freed_ready", miss_ready_o, 1'b1);
        check("freed_add", mshr_add_line_addr_o, 1'b1);
        check_addr("freed_cmp", mshr_line_addr_o, 26'h80);

        // Back-to-back issue.
        tick();
        miss_valid_i = 0; mshr_req_available_i = 1; mshr_l2c_line_addr_i = 26'h100;
        mid();
        check("b2b_put0", mshr_put_wait_o, 1'b1);
        tick();
        mshr_pending_req_i = 1; mshr_l2c_line_addr_i = 26'h140; l2c_req_ready_i = 1;
        check_addr("b2b_addr0", l2c_req_line_addr_o, 26'h100);
        mid();
        check("b2b_put1", mshr_put_wait_o, 1'b1);
        tick();
        mshr_req_available_i = 0;
        check("b2b_valid1", l2c_req_valid_o, 1'b1);
        check_addr("b2b_addr1", l2c_req_line_addr_o, 26'h140);
        tick();
        l2c_req_ready_i = 0; mshr_pending_req_i = 0;
        check("b2b_done", l2c_req_valid_o, 1'b0);

        // Answer with no matching entry sets the sticky error.
        l2c_ans_valid_i = 1; l2c_ans_line_addr_i = 26'h123; mshr_hit_i = 0;
        mid();
        check("err_no_clr_hit", mshr_clr_hit_line_o, 1'b0);
        tick();
        l2c_ans_valid_i = 0;
        check("err_set", err_o, 1'b1);
        tick(); tick();
        check("err_sticky", err_o, 1'b1);

        // Outstanding cap of 2 blocks issue until an answer retires an entry.
        mshr_pending_req_i = 2; mshr_req_available_i = 1; mshr_l2c_line_addr_i = 26'h180;
        mid();
        check("cap_block0", mshr_put_wait_o, 1'b0);
        tick();
        mid();
        check("cap_block1", mshr_put_wait_o, 1'b0);
        tick();
        l2c_ans_valid_i = 1; l2c_ans_line_addr_i = 26'h100; mshr_hit_i = 1;
        mid();
        check("cap_ans_clr_hit", mshr_clr_hit_line_o, 1'b1);
        check("cap_ans_no_put", mshr_put_wait_o, 1'b0);
        tick();
        l2c_ans_valid_i = 0; mshr_hit_i = 0; mshr_pending_req_i = 1;
        mid();
        check("cap_put", mshr_put_wait_o, 1'b1);
        tick();
        mshr_req_available_i = 0; mshr_pending_req_i = 2; l2c_req_ready_i = 1;
        check("cap_req_valid", l2c_req_valid_o, 1'b1);
        check_addr("cap_req_addr", l2c_req_line_addr_o, 26'h180);
        tick();
        l2c_req_ready_i = 0;
        check("cap_req_done", l2c_req_valid_o, 1'b0);

        // Flush with two pending and one unissued entry.
        flush_i = 1; mshr_req_available_i = 1; mshr_l2c_line_addr_i = 26'h1C0;
        miss_valid_i = 1; miss_line_addr_i = 26'h200; mshr_pending_req_i = 1;
        mid();
        check("flush_miss_blocked", miss_ready_o, 1'b0);
        check("flush_no_add", mshr_add_line_addr_o, 1'b0);
        check("flush_no_put", mshr_put_wait_o, 1'b0);
        tick();
        flush_i = 0; mshr_pending_req_i = 2;
        mid();
        check("drain_miss_blocked", miss_ready_o, 1'b0);
        check("drain_no_put", mshr_put_wait_o, 1'b0);
        check("drain_no_done", flush_done_o, 1'b0);
        tick();
        miss_valid_i = 0; l2c_ans_valid_i = 1; l2c_ans_line_addr_i = 26'h140; mshr_hit_i = 1;
        mid();
        check("drain_ans0_ready", l2c_ans_ready_o, 1'b1);
        check("drain_ans0_clr", mshr_clr_hit_line_o, 1'b1);
        tick();
        mshr_pending_req_i = 1; l2c_ans_line_addr_i = 26'h180;
        mid();
        check("drain_ans1_clr", mshr_clr_hit_line_o, 1'b1);
        check("drain_ans1_no_clr_all", mshr_clr_all_o, 1'b0);
        tick();
        mshr_pending_req_i = 0; l2c_ans_valid_i = 0; mshr_hit_i = 0;
        mid();
        check("drain_last_no_clr_all", mshr_clr_all_o, 1'b0);
        tick();
        check("clear_clr_all", mshr_clr_all_o, 1'b1);
        check("clear_done", flush_done_o, 1'b1);
        check("clear_ans_not_ready", l2c_ans_ready_o, 1'b0);
        check("clear_no_put", mshr_put_wait_o, 1'b0);
        check("clear_miss_blocked", miss_ready_o, 1'b0);
        tick();
        mshr_req_available_i = 0;
        check("run_no_clr_all", mshr_clr_all_o, 1'b0);
        check("run_no_done", flush_done_o, 1'b0);
        check("run_ans_ready", l2c_ans_ready_o, 1'b1);
        check("run_miss_ready", miss_ready_o, 1'b1);

        // Reset clears the sticky error.
        rst_ni = 1'b0;
        #2;
        check("reset_clears_err", err_o, 1'b0);
        tick();
        rst_ni = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
